// File: rtl/rv32_lsu.sv
`default_nettype none
//==============================================================================
// Module  : rv32_lsu
// Brief   : RV32I load/store unit driving a byte-write-enable data BRAM
//           with a one-cycle synchronous read and a valid/ready response.
// Revision: 1.0 - initial release
//==============================================================================
module rv32_lsu #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_cause,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_access = 2'd1;
    localparam logic [1:0]  c_st_wait   = 2'd2;
    localparam logic [1:0]  c_st_resp   = 2'd3;
    localparam logic [32:0] c_span      = 33'(4 * DEPTH_WORDS);

    logic [1:0]  r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_cause;

    logic [32:0] w_offset;
    logic        w_in_range;
    logic [1:0]  w_cause;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [31:0] w_lane;
    logic [31:0] w_ext;
    logic [31:0] w_load;

    assign req_ready = (r_state == c_st_idle);

    // 33-bit subtraction: a borrow into bit 32 means the address is below the window
    assign w_offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign w_in_range = ~w_offset[32] && (w_offset < c_span);

    always_comb begin
        w_cause = 2'b00;
        if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_we && req_funct3[2]))
            w_cause = 2'b11;
        else if (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)))
            w_cause = 2'b01;
        else if (!w_in_range)
            w_cause = 2'b10;
    end

    always_comb begin
        w_be = 4'b1111;
        w_wd = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be = 4'b0001 << req_addr[1:0];
                w_wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be = 4'b0011 << req_addr[1:0];
                w_wd = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = req_wdata;
            end
        endcase
    end

    // mem_addr still holds the request address, so its low bits select the lane
    assign w_lane = mem_rd >> {mem_addr[1:0], 3'b000};

    always_comb begin
        w_ext = mem_rd;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_ext = {24'h0, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_ext = {16'h0, w_lane[15:0]};
            default: w_ext = mem_rd;
        endcase
    end

    assign w_load = ((r_cause == 2'b00) && !r_we) ? w_ext : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_cause    <= 2'b00;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_cause <= 2'b00;
            mem_we     <= 4'b0000;
            mem_addr   <= 32'h0;
            mem_wd     <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_cause  <= w_cause;
                        mem_addr <= req_addr;
                        mem_wd   <= w_wd;
                        mem_we   <= (req_we && (w_cause == 2'b00)) ? w_be : 4'b0000;
                        r_state  <= c_st_access;
                    end
                end
                c_st_access: begin
                    mem_we  <= 4'b0000;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    resp_rdata <= w_load;
                    resp_cause <= r_cause;
                    resp_valid <= 1'b1;
                    r_state    <= c_st_resp;
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_lsu.sv
`default_nettype none
//==============================================================================
// Module  : tb_rv32_lsu
// Brief   : Directed table-driven bench for rv32_lsu with a behavioural BRAM.
// Revision: 1.0 - initial release
//==============================================================================
module tb_rv32_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks   = 0;
    int failures = 0;

    logic [31:0] bram [0:4095];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_cause;
        logic [3:0]  exp_we;
        logic [31:0] exp_wd;
        logic        chk_wd;
    } vec_t;

    vec_t vecs[$];

    rv32_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_cause (resp_cause),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // Byte-enable BRAM with one-cycle synchronous read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) bram[mem_addr[13:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        mem_rd <= bram[mem_addr[13:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic [1:0] exp_cause, input logic [3:0] exp_we,
                                input logic [31:0] exp_wd, input logic chk_wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_cause = exp_cause;
        v.exp_we = exp_we; v.exp_wd = exp_wd; v.chk_wd = chk_wd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        chk($sformatf("v%0d_ready_idle", idx), {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk($sformatf("v%0d_mem_we", idx), {28'h0, mem_we}, {28'h0, v.exp_we});
        if (v.chk_wd) chk($sformatf("v%0d_mem_wd", idx), mem_wd, v.exp_wd);
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d_ready_busy", idx), {31'h0, req_ready}, 32'h0);
        chk($sformatf("v%0d_valid_e1", idx), {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_mem_we_off", idx), {28'h0, mem_we}, 32'h0);
        chk($sformatf("v%0d_valid_e2", idx), {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", idx), {31'h0, resp_valid}, 32'h1);
        chk($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_cause", idx), {30'h0, resp_cause}, {30'h0, v.exp_cause});
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk($sformatf("v%0d_valid_drop", idx), {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) bram[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;

        //         we    f3      addr          wdata         rdata         cause  we       wd            chk_wd
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h0,        2'b00, 4'b1111, 32'hDEADBEEF, 1'b1));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,       2'b00, 4'b1000, 32'hA5A5A5A5, 1'b1));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'hFFFFFFA5, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h000000A5, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hA5ADBEEF, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0102, 32'h0000_8001, 32'h0,       2'b00, 4'b1100, 32'h80018001, 1'b1));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'hFFFF8001, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h00008001, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0101, 32'h0000_1234, 32'h0,       2'b01, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h8001BEEF, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'h0,        2'b10, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        2'b11, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0077, 32'h0,       2'b11, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b010, 32'h0000_4000, 32'h1111_1111, 32'h0,       2'b10, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h8001BEEF, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_3FFC, 32'h0,        32'h0,        2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_3FFF, 32'h0000_0080, 32'h0,       2'b00, 4'b1000, 32'h80808080, 1'b1));
        vecs.push_back(mk(1'b0, 3'b000, 32'h0000_3FFF, 32'h0,        32'hFFFFFF80, 2'b00, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        2'b01, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'h0000_4001, 32'h0,        32'h0,        2'b01, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b111, 32'h0000_0101, 32'h0,        32'h0,        2'b11, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,        32'h0,        2'b10, 4'b0000, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0000, 32'h0000_0012, 32'h0,       2'b00, 4'b0001, 32'h12121212, 1'b1));
        vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h00000012, 2'b00, 4'b0000, 32'h0,        1'b0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_cause", {30'h0, resp_cause}, 32'h0);
        chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Backpressure: response held, a second request waits until release
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
        @(posedge clk); #1;
        req_addr = 32'h0000_3FFC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_valid", {31'h0, resp_valid}, 32'h1);
        chk("bp_rdata", resp_rdata, 32'h8001BEEF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_valid", c), {31'h0, resp_valid}, 32'h1);
            chk($sformatf("bp_hold%0d_rdata", c), resp_rdata, 32'h8001BEEF);
            chk($sformatf("bp_hold%0d_cause", c), {30'h0, resp_cause}, 32'h0);
            chk($sformatf("bp_hold%0d_ready", c), {31'h0, req_ready}, 32'h0);
            chk($sformatf("bp_hold%0d_mem_we", c), {28'h0, mem_we}, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_release_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_release_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_second_taken", {31'h0, req_ready}, 32'h0);
        chk("bp_second_addr", mem_addr, 32'h0000_3FFC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_second_valid", {31'h0, resp_valid}, 32'h1);
        chk("bp_second_rdata", resp_rdata, 32'h80000000);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset during the ACCESS cycle of a store
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0000_0200; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rs_access_we", {28'h0, mem_we}, 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("rs_mem_we", {28'h0, mem_we}, 32'h0);
        chk("rs_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(mk(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 2'b00, 4'b0000, 32'h0, 1'b0), 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
